// File: rtl/e_mdu_pkg.sv
// Shared opcode encoding and decode helpers for the E-stage multiply/divide unit.
package e_mdu_pkg;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  function automatic logic is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_start(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || is_div(op);
  endfunction

  function automatic logic is_move(input logic [3:0] op);
    return (op == OP_MTHI) || (op == OP_MTLO);
  endfunction

endpackage

// File: rtl/e_mdu_if.sv
// E-stage decoder <-> multiply/divide unit signal bundle.
interface e_mdu_if #(
  parameter int WIDTH = 32
);
  logic [3:0]       E_md_op;
  logic [WIDTH-1:0] E_data1;
  logic [WIDTH-1:0] E_data2;
  logic             D_is_md;
  logic [WIDTH-1:0] E_md_out;
  logic             E_md_busy;
  logic             E_md_stall;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output E_md_op, E_data1, E_data2, D_is_md,
    input  E_md_out, E_md_busy, E_md_stall, HI, LO
  );

  modport slave (
    input  E_md_op, E_data1, E_data2, D_is_md,
    output E_md_out, E_md_busy, E_md_stall, HI, LO
  );
endinterface

// File: rtl/e_mdu_md_calc.sv
// Combinational product / quotient-remainder datapath; result is latched by the
// top when an operation starts, so no path reaches HI/LO directly.
module md_calc
  import e_mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [2*WIDTH-1:0] prod_s;
  logic        [2*WIDTH-1:0] prod_u;
  logic                      b_zero;
  logic                      div_ovf;

  assign prod_s  = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
  assign prod_u  = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  assign b_zero  = (b == '0);
  // most-negative / -1 overflows; handled explicitly so it wraps predictably
  assign div_ovf = (a == MIN_NEG) && (&b);

  always_comb begin
    hi       = '0;
    lo       = '0;
    div_zero = is_div(op) && b_zero;
    case (op)
      OP_MULT:  {hi, lo} = prod_s;
      OP_MULTU: {hi, lo} = prod_u;
      OP_DIV: begin
        if (div_ovf) begin
          lo = MIN_NEG;
          hi = '0;
        end else if (!b_zero) begin
          lo = $signed(a) / $signed(b);
          hi = $signed(a) % $signed(b);
        end
      end
      OP_DIVU: begin
        if (!b_zero) begin
          lo = a / b;
          hi = a % b;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: HI/LO pair, busy-counter latency model, stall request.
// state   | meaning
// ST_IDLE | cnt==0, accepts start and MTHI/MTLO
// ST_BUSY | cnt counting down, result commits on cnt==1
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = $clog2(((MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES) + 1)
) (
  input logic   clk,
  input logic   reset,
  e_mdu_if.slave md
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] pend_hi_q, pend_lo_q;
  logic             pend_ok_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [WIDTH-1:0] calc_hi, calc_lo;
  logic             calc_dz;
  logic             load, commit;

  md_calc #(.WIDTH(WIDTH)) u_calc (
    .op       (md.E_md_op),
    .a        (md.E_data1),
    .b        (md.E_data2),
    .hi       (calc_hi),
    .lo       (calc_lo),
    .div_zero (calc_dz)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (is_start(md.E_md_op)) begin
          load    = 1'b1;
          state_d = ST_BUSY;
          cnt_d   = is_div(md.E_md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          commit  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_ok_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) begin
        pend_hi_q <= calc_hi;
        pend_lo_q <= calc_lo;
        pend_ok_q <= !calc_dz;
      end
      // divide-by-zero runs the full latency but leaves HI/LO alone
      if (commit) begin
        if (pend_ok_q) begin
          hi_q <= pend_hi_q;
          lo_q <= pend_lo_q;
        end
      end else if (state_q == ST_IDLE && is_move(md.E_md_op)) begin
        if (md.E_md_op == OP_MTHI) hi_q <= md.E_data1;
        else                       lo_q <= md.E_data1;
      end
    end
  end

  assign md.E_md_busy  = (state_q == ST_BUSY);
  assign md.E_md_stall = md.D_is_md && ((state_q == ST_BUSY) || is_start(md.E_md_op));
  assign md.E_md_out   = (md.E_md_op == OP_MFHI) ? hi_q :
                         (md.E_md_op == OP_MFLO) ? lo_q : '0;
  assign md.HI         = hi_q;
  assign md.LO         = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Scoreboard bench for e_mdu: expected HI/LO queued at issue, popped at commit.
module tb_e_mdu;
  import e_mdu_pkg::*;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [63:0] sb_q[$];
  logic [31:0] m_hi, m_lo;

  e_mdu_if #(.WIDTH(32)) bus ();

  e_mdu #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] h,
                                        input logic [31:0] l);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0] res;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    res = {h, l};
    case (op)
      OP_MULT:  res = sa * sb;
      OP_MULTU: res = ua * ub;
      OP_DIV: if (b != 0) begin
        q   = sa / sb;
        r   = sa % sb;
        res = {r[31:0], q[31:0]};
      end
      OP_DIVU: if (b != 0) begin
        q   = longint'(ua / ub);
        r   = longint'(ua % ub);
        res = {r[31:0], q[31:0]};
      end
      default: ;
    endcase
    return res;
  endfunction

  task automatic run_calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic dmd, input bit inject);
    int n, bc, sc;
    logic [63:0] e;
    n = is_div(op) ? 10 : 5;
    sb_q.push_back(model(op, a, b, m_hi, m_lo));
    bus.D_is_md = dmd;
    bus.E_md_op = op;
    bus.E_data1 = a;
    bus.E_data2 = b;
    #1;
    sc = bus.E_md_stall ? 1 : 0;
    bc = 0;
    tick();
    bus.E_md_op = OP_NONE;
    bus.E_data1 = $urandom;
    bus.E_data2 = $urandom;
    #1;
    while (bus.E_md_busy && bc < 100) begin
      bc++;
      if (bus.E_md_stall) sc++;
      // ops issued while busy must not disturb the pending result
      if (inject && bc == 2)      bus.E_md_op = OP_MTLO;
      else if (inject && bc == 3) bus.E_md_op = OP_MULT;
      else                        bus.E_md_op = OP_NONE;
      tick();
    end
    bus.E_md_op = OP_NONE;
    #1;
    chk("busy_cycles", 64'(bc), 64'(n));
    chk("stall_cycles", 64'(sc), dmd ? 64'(n + 1) : 64'd0);
    chk("stall_commit", 64'(bus.E_md_stall), 64'd0);
    e = sb_q.pop_front();
    chk("hi_commit", 64'(bus.HI), 64'(e[63:32]));
    chk("lo_commit", 64'(bus.LO), 64'(e[31:0]));
    m_hi = e[63:32];
    m_lo = e[31:0];
    bus.D_is_md = 1'b0;
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] val);
    bus.E_md_op = op;
    bus.E_data1 = val;
    tick();
    bus.E_md_op = OP_NONE;
    if (op == OP_MTHI) m_hi = val;
    else               m_lo = val;
  endtask

  task automatic rd_check();
    bus.E_md_op = OP_MFHI;
    #1 chk("mfhi", 64'(bus.E_md_out), 64'(m_hi));
    bus.E_md_op = OP_MFLO;
    #1 chk("mflo", 64'(bus.E_md_out), 64'(m_lo));
    bus.E_md_op = OP_NONE;
    #1 chk("out_none", 64'(bus.E_md_out), 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    reset       = 1'b0;
    bus.E_md_op = OP_MULT;
    bus.E_data1 = 32'd3;
    bus.E_data2 = 32'd4;
    bus.D_is_md = 1'b1;
    m_hi        = '0;
    m_lo        = '0;
    tick();
    tick();
    chk("rst_busy", 64'(bus.E_md_busy), 64'd0);
    chk("rst_hi", 64'(bus.HI), 64'd0);
    chk("rst_lo", 64'(bus.LO), 64'd0);
    chk("rst_out", 64'(bus.E_md_out), 64'd0);
    chk("rst_stall", 64'(bus.E_md_stall), 64'd1);
    bus.E_md_op = OP_NONE;
    bus.D_is_md = 1'b0;
    reset       = 1'b1;
    tick();

    run_calc(OP_MULT,  32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 1'b0);
    rd_check();
    run_calc(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b0);
    rd_check();
    run_calc(OP_DIV,   32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    run_calc(OP_DIVU,  32'd7, 32'd2, 1'b1, 1'b0);
    rd_check();

    mt(OP_MTHI, 32'h11);
    mt(OP_MTLO, 32'h22);
    rd_check();
    run_calc(OP_DIV, 32'd1234, 32'd0, 1'b0, 1'b0);
    run_calc(OP_DIVU, 32'd99, 32'd0, 1'b1, 1'b0);
    rd_check();

    run_calc(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_calc(OP_MULT, 32'h0001_2345, 32'hFFFF_0007, 1'b1, 1'b1);
    run_calc(OP_DIV, 32'h7654_3210, 32'hFFFF_FF03, 1'b0, 1'b1);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom_range(1, 500);
      run_calc(4'(1 + (i % 4)), ra, rb, i[0], 1'b0);
    end
    rd_check();

    // reset in the third busy cycle discards the in-flight result
    bus.E_md_op = OP_MULT;
    bus.E_data1 = 32'd3;
    bus.E_data2 = 32'd4;
    tick();
    bus.E_md_op = OP_NONE;
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("midrst_busy", 64'(bus.E_md_busy), 64'd0);
    chk("midrst_hi", 64'(bus.HI), 64'd0);
    chk("midrst_lo", 64'(bus.LO), 64'd0);
    repeat (8) tick();
    chk("midrst_busy_late", 64'(bus.E_md_busy), 64'd0);
    chk("midrst_hi_late", 64'(bus.HI), 64'd0);
    chk("midrst_lo_late", 64'(bus.LO), 64'd0);
    m_hi = '0;
    m_lo = '0;
    run_calc(OP_MULTU, 32'd6, 32'd7, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/e_mdu.md
# e_mdu

Execute-stage multiply/divide unit for the five-stage MIPS pipeline, sitting beside the E-stage ALU and driven by the E-stage decoder's multiply/divide opcode. It accepts MULT/MULTU/DIV/DIVU, holds the HI/LO pair, and serves MFHI/MFLO/MTHI/MTLO. It models a parametrised multi-cycle latency with a busy counter and raises the stall request the hazard unit needs to hold D-stage multiply/divide instructions.

## Interface
- WIDTH, 32, operand and HI/LO width
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (≥1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (≥1)
- CNT_W, $clog2(max(MULT_CYCLES,DIV_CYCLES)+1), counter width

- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-low (0 = reset)
- E_md_op  in  4  operation code (package encoding)
- E_data1  in  WIDTH  forwarded rs value
- E_data2  in  WIDTH  forwarded rt value
- D_is_md  in  1  D-stage instruction is any multiply/divide/HI/LO op
- E_md_out  out  WIDTH  HI for MFHI, LO for MFLO, else 0
- E_md_busy  out  1  calculation in progress
- E_md_stall  out  1  stall request to hazard unit
- HI  out  WIDTH  architectural HI
- LO  out  WIDTH  architectural LO

## Operation
- Opcodes: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8; 9–15 treated as NONE.
- States: IDLE (cnt==0), BUSY (cnt!=0). E_md_busy = (cnt!=0).
- IDLE + start op (1–4): on edge, latch pending {hi,lo} result, load cnt with MULT_CYCLES or DIV_CYCLES → BUSY.
- BUSY: each edge cnt−1; on edge where cnt==1, HI/LO ← pending, cnt→0 → IDLE.
- Start op while BUSY: ignored entirely (pending/cnt untouched); hazard logic guarantees absence, bench checks no corruption.
- MULT: {HI,LO} = signed E_data1 × signed E_data2, full 2·WIDTH product. MULTU unsigned.
- DIV: LO = quotient truncated toward zero, HI = remainder with sign of dividend. DIVU unsigned.
- Divide by zero (E_data2==0): counter runs normally, HI/LO unchanged at commit.
- DIV of most-negative by −1: LO = most-negative, HI = 0 (wraps, no trap).
- MTHI/MTLO in IDLE: HI/LO ← E_data1 on edge. In BUSY: ignored.
- MFHI/MFLO: E_md_out combinational from current HI/LO.
- E_md_stall = D_is_md && (E_md_busy || E_md_op ∈ {1,2,3,4}).

## Timing
- Reset (reset==0 at edge): HI=0, LO=0, cnt=0, pending=0; outputs E_md_busy=0, E_md_out=0, E_md_stall=D_is_md && start op (combinational).
- Reset mid-calculation discards pending result; HI/LO cleared.
- Start sampled at edge t: busy high cycles t+1…t+N; HI/LO new value visible after edge t+N, same edge busy drops.
- Back-to-back: new start accepted in first IDLE cycle after commit (no bubble beyond stall).
- E_md_out reflects register value; MFHI in same cycle as an MTHI returns old HI.
- No combinational path from E_data* to HI/LO outputs.

## Structure
- Package e_mdu_pkg: opcode localparams, is_start/is_move helper functions.
- Sub-module md_calc: combinational signed/unsigned product and quotient/remainder, divide-by-zero flag, parametrised on WIDTH.
- Top holds counter, pending registers, HI/LO, stall/out logic.

## Test plan
- MULT 0xFFFFFFFF × 0x00000002 → after 5 busy cycles HI=0xFFFFFFFF, LO=0xFFFFFFFE; MULTU same → HI=0x1, LO=0xFFFFFFFE.
- DIV −7 / 2 → after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/2 → LO=3, HI=1.
- DIV by 0 with HI=0x11, LO=0x22 preset via MTHI/MTLO → busy 10 cycles, HI/LO unchanged.
- D_is_md=1 during MULT start and busy → E_md_stall high 6 cycles (start + 5), drops on commit cycle; D_is_md=0 → never stalls.
- MTLO / second MULT issued while busy → ignored, first result commits intact.
- reset=0 at busy cycle 3 → next cycle busy=0, HI=LO=0, no later commit.
